// File: rtl/hazard_if.sv
// Signal bundle between the pipeline segment registers and the hazard controller.
// The master side drives register addresses and control flags; the slave side returns the hazard, forwarding and counter outputs.
interface hazard_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       reg1_src_ID;
    logic [4:0]       reg2_src_ID;
    logic [4:0]       reg1_src_EX;
    logic [4:0]       reg2_src_EX;
    logic [4:0]       reg_dest_EX;
    logic [4:0]       reg_dest_MEM;
    logic [4:0]       reg_dest_WB;
    logic             load_EX;
    logic             reg_write_MEM;
    logic             reg_write_WB;
    logic             br_taken_EX;
    logic             jalr_EX;
    logic             jal_ID;
    logic             miss;
    logic             cnt_clr;

    logic             bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic             flushF, flushD, flushE, flushM, flushW;
    logic [1:0]       op1_sel;
    logic [1:0]       op2_sel;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output reg1_src_ID, reg2_src_ID, reg1_src_EX, reg2_src_EX,
        output reg_dest_EX, reg_dest_MEM, reg_dest_WB,
        output load_EX, reg_write_MEM, reg_write_WB,
        output br_taken_EX, jalr_EX, jal_ID, miss, cnt_clr,
        input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
        input  flushF, flushD, flushE, flushM, flushW,
        input  op1_sel, op2_sel, stall_cycles, flush_events
    );

    modport slave (
        input  reg1_src_ID, reg2_src_ID, reg1_src_EX, reg2_src_EX,
        input  reg_dest_EX, reg_dest_MEM, reg_dest_WB,
        input  load_EX, reg_write_MEM, reg_write_WB,
        input  br_taken_EX, jalr_EX, jal_ID, miss, cnt_clr,
        output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
        output flushF, flushD, flushE, flushM, flushW,
        output op1_sel, op2_sel, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: bubble/flush generation, EX forwarding,
// data-cache-miss stall FSM with programmable resume delay, and stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned RESUME_CYCLES = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hz
);
    localparam int unsigned RES_W       = 4;
    localparam logic [RES_W-1:0] RESUME_INIT = RES_W'(RESUME_CYCLES);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_MISS   = 2'd1,
        S_RESUME = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [RES_W-1:0] r_resume_cnt;
    logic [RES_W-1:0] w_resume_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_stalled;
    logic w_branch;
    logic w_load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       wr_mem, input logic [4:0] rd_mem,
                                           input logic       wr_wb,  input logic [4:0] rd_wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0 && wr_mem && rd_mem == src)     sel = 2'b10;
        else if (src != 5'd0 && wr_wb && rd_wb == src)  sel = 2'b01;
        return sel;
    endfunction

    // Stall FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_resume_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_resume_cnt <= w_resume_nxt;
        end
    end

    // Stall FSM next state; a new miss always wins over the resume countdown
    always_comb begin
        w_state_nxt  = r_state;
        w_resume_nxt = r_resume_cnt;
        case (r_state)
            S_RUN: begin
                if (hz.miss) w_state_nxt = S_MISS;
            end
            S_MISS: begin
                if (!hz.miss) begin
                    w_resume_nxt = RESUME_INIT;
                    w_state_nxt  = (RESUME_CYCLES > 0) ? S_RESUME : S_RUN;
                end
            end
            S_RESUME: begin
                if (hz.miss) begin
                    w_state_nxt = S_MISS;
                end else begin
                    w_resume_nxt = r_resume_cnt - RES_W'(1);
                    if (r_resume_cnt == RES_W'(1)) w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign w_stalled  = (r_state != S_RUN);
    assign w_branch   = hz.br_taken_EX | hz.jalr_EX;
    assign w_load_use = hz.load_EX && (hz.reg_dest_EX != 5'd0) &&
                        ((hz.reg_dest_EX == hz.reg1_src_ID) || (hz.reg_dest_EX == hz.reg2_src_ID));

    // Segment-register control, zero latency; stall hold overrides everything
    always_comb begin
        hz.bubbleF = 1'b0;
        hz.bubbleD = 1'b0;
        hz.bubbleE = 1'b0;
        hz.bubbleM = 1'b0;
        hz.bubbleW = 1'b0;
        hz.flushF  = 1'b0;
        hz.flushD  = 1'b0;
        hz.flushE  = 1'b0;
        hz.flushM  = 1'b0;
        hz.flushW  = 1'b0;
        if (w_stalled) begin
            hz.bubbleF = 1'b1;
            hz.bubbleD = 1'b1;
            hz.bubbleE = 1'b1;
            hz.bubbleM = 1'b1;
            hz.bubbleW = 1'b1;
        end else if (w_branch) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
        end else if (w_load_use) begin
            hz.bubbleF = 1'b1;
            hz.bubbleD = 1'b1;
            hz.flushE  = 1'b1;
        end else if (hz.jal_ID) begin
            hz.flushD = 1'b1;
        end
    end

    assign hz.op1_sel = fwd_sel(hz.reg1_src_EX, hz.reg_write_MEM, hz.reg_dest_MEM,
                                hz.reg_write_WB, hz.reg_dest_WB);
    assign hz.op2_sel = fwd_sel(hz.reg2_src_EX, hz.reg_write_MEM, hz.reg_dest_MEM,
                                hz.reg_write_WB, hz.reg_dest_WB);

    // Wrapping performance counters; clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (hz.cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (hz.bubbleF)              r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (!w_stalled && w_branch)  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = r_stall_cnt;
    assign hz.flush_events = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (resume delay 2 / 32-bit counters, resume delay 3 / 4-bit counters)
// share one stimulus stream and are compared against a stall-countdown reference model.
module tb_hazard_ctrl;
    typedef struct packed {
        logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
        logic       load_ex, rw_mem, rw_wb, br, jalr, jal, miss, clr;
    } in_t;

    typedef struct {
        in_t         v;
        logic [13:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    in_t  vin;
    always #5 clk = ~clk;

    hazard_if #(.CNT_W(32)) if_a();
    hazard_if #(.CNT_W(4))  if_b();

    hazard_ctrl #(.RESUME_CYCLES(2), .CNT_W(32)) u_dut_a (.clk(clk), .rst_n(rst_n), .hz(if_a.slave));
    hazard_ctrl #(.RESUME_CYCLES(3), .CNT_W(4))  u_dut_b (.clk(clk), .rst_n(rst_n), .hz(if_b.slave));

    always_comb begin
        if_a.reg1_src_ID = vin.rs1_id;   if_b.reg1_src_ID = vin.rs1_id;
        if_a.reg2_src_ID = vin.rs2_id;   if_b.reg2_src_ID = vin.rs2_id;
        if_a.reg1_src_EX = vin.rs1_ex;   if_b.reg1_src_EX = vin.rs1_ex;
        if_a.reg2_src_EX = vin.rs2_ex;   if_b.reg2_src_EX = vin.rs2_ex;
        if_a.reg_dest_EX = vin.rd_ex;    if_b.reg_dest_EX = vin.rd_ex;
        if_a.reg_dest_MEM = vin.rd_mem;  if_b.reg_dest_MEM = vin.rd_mem;
        if_a.reg_dest_WB = vin.rd_wb;    if_b.reg_dest_WB = vin.rd_wb;
        if_a.load_EX = vin.load_ex;      if_b.load_EX = vin.load_ex;
        if_a.reg_write_MEM = vin.rw_mem; if_b.reg_write_MEM = vin.rw_mem;
        if_a.reg_write_WB = vin.rw_wb;   if_b.reg_write_WB = vin.rw_wb;
        if_a.br_taken_EX = vin.br;       if_b.br_taken_EX = vin.br;
        if_a.jalr_EX = vin.jalr;         if_b.jalr_EX = vin.jalr;
        if_a.jal_ID = vin.jal;           if_b.jal_ID = vin.jal;
        if_a.miss = vin.miss;            if_b.miss = vin.miss;
        if_a.cnt_clr = vin.clr;          if_b.cnt_clr = vin.clr;
    end

    // {bF,bD,bE,bM,bW, fF,fD,fE,fM,fW, op1_sel, op2_sel}
    logic [13:0] out_a, out_b;
    assign out_a = {if_a.bubbleF, if_a.bubbleD, if_a.bubbleE, if_a.bubbleM, if_a.bubbleW,
                    if_a.flushF, if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW,
                    if_a.op1_sel, if_a.op2_sel};
    assign out_b = {if_b.bubbleF, if_b.bubbleD, if_b.bubbleE, if_b.bubbleM, if_b.bubbleW,
                    if_b.flushF, if_b.flushD, if_b.flushE, if_b.flushM, if_b.flushW,
                    if_b.op1_sel, if_b.op2_sel};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: a miss flag plus a count of remaining resume-hold cycles per instance
    bit              m_inmiss [2];
    int              m_left   [2];
    int              m_resume [2] = '{2, 3};
    longint unsigned m_stall  [2];
    longint unsigned m_flush  [2];

    function automatic longint unsigned cmask(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] src, input in_t v);
        if (src != 0 && v.rw_mem && v.rd_mem == src) return 2'b10;
        if (src != 0 && v.rw_wb && v.rd_wb == src)   return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] exp_out(input in_t v, input bit stalled);
        logic [9:0] bf;
        if (stalled)                 bf = 10'b11111_00000;
        else if (v.br || v.jalr)     bf = 10'b00000_01100;
        else if (v.load_ex && v.rd_ex != 0 && (v.rd_ex == v.rs1_id || v.rd_ex == v.rs2_id))
                                     bf = 10'b11000_00100;
        else if (v.jal)              bf = 10'b00000_01000;
        else                         bf = 10'b0;
        return {bf, fwd(v.rs1_ex, v), fwd(v.rs2_ex, v)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_inmiss[k] = 1'b0;
            m_left[k]   = 0;
            m_stall[k]  = 0;
            m_flush[k]  = 0;
        end
    endtask

    // Apply one cycle of inputs, compare both instances, then advance the model over the coming edge
    task automatic step(input in_t v, input string name);
        logic [13:0]     e, act;
        longint unsigned sa, fa;
        bit              st;
        @(negedge clk);
        vin = v;
        #1;
        for (int k = 0; k < 2; k++) begin
            st  = m_inmiss[k] || (m_left[k] > 0);
            e   = exp_out(v, st);
            act = (k == 0) ? out_a : out_b;
            sa  = (k == 0) ? 64'(if_a.stall_cycles) : 64'(if_b.stall_cycles);
            fa  = (k == 0) ? 64'(if_a.flush_events) : 64'(if_b.flush_events);
            check($sformatf("%s_out%0d", name, k),   64'(act), 64'(e));
            check($sformatf("%s_stall%0d", name, k), sa, m_stall[k]);
            check($sformatf("%s_flush%0d", name, k), fa, m_flush[k]);
            if (v.clr) begin
                m_stall[k] = 0;
                m_flush[k] = 0;
            end else begin
                m_stall[k] = (m_stall[k] + 64'(e[13])) & cmask(k);
                m_flush[k] = (m_flush[k] + 64'(!st && (v.br || v.jalr))) & cmask(k);
            end
            if (v.miss) begin
                m_inmiss[k] = 1'b1;
                m_left[k]   = 0;
            end else if (m_inmiss[k]) begin
                m_inmiss[k] = 1'b0;
                m_left[k]   = m_resume[k];
            end else if (m_left[k] > 0) begin
                m_left[k]--;
            end
        end
    endtask

    vec_t tab[$];

    task automatic add(input in_t v, input logic [13:0] exp, input string name);
        vec_t r;
        r.v = v; r.exp = exp; r.name = name;
        tab.push_back(r);
    endtask

    initial begin
        in_t      v, z;
        logic [6:0] seq7;
        logic [7:0] seq8;
        logic [8:0] seq9;
        bit       rmiss;

        z = '0;
        vin = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check("reset_out_a", 64'(out_a), 64'(0));
        check("reset_out_b", 64'(out_b), 64'(0));
        check("reset_stall_a", 64'(if_a.stall_cycles), 64'(0));
        check("reset_flush_b", 64'(if_b.flush_events), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        v = z; v.load_ex = 1; v.rd_ex = 5; v.rs2_id = 5;        add(v, 14'b11000_00100_00_00, "load_use");
        v.rd_ex = 0; v.rs2_id = 0;                              add(v, 14'b0, "load_use_x0");
        v = z; v.load_ex = 1; v.rd_ex = 3; v.rs1_id = 3;        add(v, 14'b11000_00100_00_00, "load_use_rs1");
        v.load_ex = 0;                                          add(v, 14'b0, "no_load");
        v = z; v.rd_mem = 7; v.rd_wb = 7; v.rw_mem = 1; v.rw_wb = 1; v.rs1_ex = 7;
                                                                add(v, 14'b00000_00000_10_00, "fwd_mem");
        v.rw_mem = 0;                                           add(v, 14'b00000_00000_01_00, "fwd_wb");
        v.rw_mem = 1; v.rs1_ex = 0;                             add(v, 14'b0, "fwd_x0");
        v = z; v.rd_mem = 9; v.rd_wb = 9; v.rw_mem = 1; v.rw_wb = 1; v.rs2_ex = 9; v.rs1_ex = 9;
                                                                add(v, 14'b00000_00000_10_10, "fwd_both_mem");
        v = z; v.br = 1; v.load_ex = 1; v.rd_ex = 5; v.rs1_id = 5;
                                                                add(v, 14'b00000_01100_00_00, "br_over_lu");
        v = z; v.jalr = 1; v.jal = 1;                           add(v, 14'b00000_01100_00_00, "jalr");
        v = z; v.jal = 1;                                       add(v, 14'b00000_01000_00_00, "jal");
        v = z; v.jal = 1; v.load_ex = 1; v.rd_ex = 2; v.rs2_id = 2;
                                                                add(v, 14'b11000_00100_00_00, "lu_over_jal");

        foreach (tab[i]) begin
            step(tab[i].v, tab[i].name);
            check({tab[i].name, "_tab"}, 64'(out_a), 64'(tab[i].exp));
        end

        // Miss held 3 cycles with resume delay 2: five consecutive all-stage holds
        v = z; v.clr = 1; step(v, "clr1");
        for (int i = 0; i < 7; i++) begin
            v = z; v.miss = (i < 3);
            step(v, "miss3");
            seq7[6-i] = if_a.bubbleF;
        end
        check("miss3_pattern", 64'(seq7), 64'(7'b0111110));
        check("miss3_stall_cnt", 64'(if_a.stall_cycles), 64'(5));

        // Taken branch during a miss: suppressed while held, fires once on first RUN cycle
        v = z; v.clr = 1; step(v, "clr2");
        for (int i = 0; i < 8; i++) begin
            v = z; v.miss = (i < 3); v.br = (i >= 1 && i < 7);
            step(v, "miss_br");
            seq8[7-i] = if_a.flushD;
        end
        check("miss_br_pattern", 64'(seq8), 64'(8'b00000010));
        check("miss_br_flush_cnt", 64'(if_a.flush_events), 64'(1));

        // Miss reasserted at resume cycle 2 (delay 3 instance): counter reloads after the drop
        v = z; v.clr = 1; step(v, "clr3");
        for (int i = 0; i < 9; i++) begin
            v = z; v.miss = (i == 0 || i == 3);
            step(v, "miss_re");
            seq9[8-i] = if_b.bubbleF;
        end
        check("miss_re_pattern", 64'(seq9), 64'(9'b011111110));

        // Clear coinciding with an increment
        v = z; v.load_ex = 1; v.rd_ex = 4; v.rs1_id = 4; step(v, "lu_inc");
        v.clr = 1; step(v, "lu_clr");
        step(z, "after_clr");
        check("clr_wins", 64'(if_a.stall_cycles), 64'(0));

        // Asynchronous reset in the middle of a miss
        v = z; v.miss = 1; step(v, "pre_rst0"); step(v, "pre_rst1");
        check("in_miss", 64'(if_a.bubbleF), 64'(1));
        #1;
        vin = z;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_miss_a", 64'(out_a), 64'(0));
        check("rst_mid_miss_b", 64'(out_b), 64'(0));
        check("rst_cnt_a", 64'(if_a.stall_cycles), 64'(0));
        check("rst_cnt_b", 64'(if_b.stall_cycles), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        v = z; v.jal = 1; step(v, "post_rst");

        // Randomized traffic with sticky miss; small register range to provoke matches
        rmiss = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) rmiss = ~rmiss;
            v.rs1_id  = 5'($urandom_range(0, 3));
            v.rs2_id  = 5'($urandom_range(0, 3));
            v.rs1_ex  = 5'($urandom_range(0, 3));
            v.rs2_ex  = 5'($urandom_range(0, 3));
            v.rd_ex   = 5'($urandom_range(0, 3));
            v.rd_mem  = 5'($urandom_range(0, 3));
            v.rd_wb   = 5'($urandom_range(0, 3));
            v.load_ex = 1'($urandom_range(0, 1));
            v.rw_mem  = 1'($urandom_range(0, 1));
            v.rw_wb   = 1'($urandom_range(0, 1));
            v.br      = ($urandom_range(0, 5) == 0);
            v.jalr    = ($urandom_range(0, 9) == 0);
            v.jal     = ($urandom_range(0, 5) == 0);
            v.miss    = rmiss;
            v.clr     = ($urandom_range(0, 63) == 0);
            step(v, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
